// File: rtl/uarc_send_arbiter.sv
// Round-robin arbiter that merges several UARC send channels into one
// single-entry buffered send channel, with optional per-requester burst lock.
module uarc_send_arbiter #(
   parameter int WORD_WIDTH = 32,
   parameter int REQUESTERS = 4,
   parameter int SEL_WIDTH  = $clog2(REQUESTERS)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [REQUESTERS-1:0]                req_sends,
   input  logic [REQUESTERS-1:0]                req_streams,
   input  logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_datas,
   output logic [REQUESTERS-1:0]                req_send_acks,
   output logic                                 out_send,
   output logic [WORD_WIDTH-1:0]                out_data,
   output logic [SEL_WIDTH-1:0]                 out_source,
   input  logic                                 out_send_ack,
   output logic                                 busy
);

   logic [SEL_WIDTH-1:0]  ptr;
   logic [SEL_WIDTH-1:0]  lock_owner;
   logic [SEL_WIDTH-1:0]  winner;
   logic [SEL_WIDTH-1:0]  idx;
   logic [31:0]           sum;
   logic [REQUESTERS-1:0] eligible;
   logic                  found;
   logic                  can_capture;
   logic                  capture;
   logic                  abandon;

   assign can_capture = !out_send || out_send_ack;
   assign capture     = !reset && can_capture && found;
   // The owner gives up the lock by going fully idle (no word, no stream intent).
   assign abandon     = busy && !req_sends[lock_owner] && !req_streams[lock_owner];

   always_comb begin
      eligible = '0;
      if (busy)
         eligible[lock_owner] = req_sends[lock_owner];
      else
         eligible = req_sends;
   end

   // Search starts one past the last winner so the last winner is checked last.
   always_comb begin
      winner = lock_owner;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 1; k <= REQUESTERS; k++) begin
         sum = 32'(ptr) + 32'(k);
         if (sum >= 32'(REQUESTERS))
            sum = sum - 32'(REQUESTERS);
         idx = SEL_WIDTH'(sum);
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      req_send_acks = '0;
      if (capture)
         req_send_acks[winner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_send   <= 1'b0;
         out_data   <= '0;
         out_source <= '0;
         busy       <= 1'b0;
         lock_owner <= '0;
         ptr        <= SEL_WIDTH'(REQUESTERS - 1);
      end else if (capture) begin
         out_send   <= 1'b1;
         out_data   <= req_datas[winner];
         out_source <= winner;
         ptr        <= winner;
         // While locked the winner is always the owner, so this both sets and releases.
         busy       <= req_streams[winner];
         if (req_streams[winner])
            lock_owner <= winner;
      end else begin
         if (out_send_ack)
            out_send <= 1'b0;
         if (abandon)
            busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uarc_send_arbiter.sv
// Scenario bench for uarc_send_arbiter: per-feature tasks plus a scoreboard of
// expected {source, data} words checked whenever the output channel transfers.
module tb_uarc_send_arbiter;

   localparam int W = 32;
   localparam int R = 4;
   localparam int S = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [R-1:0]      sends;
   logic [R-1:0]      streams;
   logic [R-1:0][W-1:0] datas;
   logic [R-1:0]      acks;
   logic              out_send;
   logic [W-1:0]      out_data;
   logic [S-1:0]      out_source;
   logic              out_ack;
   logic              busy;

   int checks = 0;
   int passes = 0;
   int last   = 0;
   logic [S+W-1:0] sb[$];
   logic [S+W-1:0] mon_e;

   uarc_send_arbiter #(.WORD_WIDTH(W), .REQUESTERS(R)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_sends    (sends),
      .req_streams  (streams),
      .req_datas    (datas),
      .req_send_acks(acks),
      .out_send     (out_send),
      .out_data     (out_data),
      .out_source   (out_source),
      .out_send_ack (out_ack),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Output-side scoreboard: every transfer must match the oldest predicted word.
   always @(negedge clk) begin
      if (!reset && out_send && out_ack) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got src %0d data %h, want no transfer", out_source, out_data);
         end else begin
            mon_e = sb.pop_front();
            if ({out_source, out_data} !== mon_e)
               $display("FAIL sb_word: got src %0d data %h, want src %0d data %h",
                        out_source, out_data, mon_e[S+W-1:W], mon_e[W-1:0]);
            else
               passes++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; sends = '0; streams = '0; out_ack = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; sends = 4'hF; streams = '0; out_ack = 1'b0;
      for (int i = 0; i < R; i++) datas[i] = 32'hA0 + 32'(i);
      tick();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (out_send !== 1'b0) $display("FAIL reset_out_send: got %b want 0", out_send); else passes++;
         checks++; if (acks !== 4'b0000) $display("FAIL reset_acks: got %b want 0000", acks); else passes++;
         checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
         tick();
      end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (acks !== 4'b0001) $display("FAIL reset_first_ack: got %b want 0001", acks); else passes++;
      sb.push_back({2'd0, 32'hA0});
      tick();
      checks++; if (out_send !== 1'b1) $display("FAIL reset_latency: got %b want 1", out_send); else passes++;
      @(negedge clk);
      checks++; if (acks !== 4'b0000) $display("FAIL full_buffer_acks: got %b want 0000", acks); else passes++;
      out_ack = 1'b1; sends = '0;
      tick();
      checks++; if (out_send !== 1'b0) $display("FAIL reset_drain: got %b want 0", out_send); else passes++;
      out_ack = 1'b0;
      last = 0;
   endtask

   task automatic test_single();
      logic [W-1:0] words [3];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
      out_ack = 1'b1; sends = 4'b0100; streams = '0;
      for (int k = 0; k < 3; k++) begin
         datas[2] = words[k];
         @(negedge clk);
         checks++; if (acks !== 4'b0100) $display("FAIL single_ack: got %b want 0100", acks); else passes++;
         sb.push_back({2'd2, words[k]});
         tick();
         checks++; if (out_send !== 1'b1) $display("FAIL single_gap: got %b want 1", out_send); else passes++;
         checks++; if (out_data !== words[k]) $display("FAIL single_data: got %h want %h", out_data, words[k]); else passes++;
         checks++; if (out_source !== 2'd2) $display("FAIL single_source: got %0d want 2", out_source); else passes++;
      end
      sends = '0;
      tick();
      checks++; if (out_send !== 1'b0) $display("FAIL single_empty: got %b want 0", out_send); else passes++;
      last = 2;
   endtask

   task automatic test_round_robin();
      int cnt [R];
      int w;
      for (int i = 0; i < R; i++) begin
         cnt[i] = 0;
         datas[i] = 32'hA0 + 32'(i);
      end
      out_ack = 1'b1; sends = 4'hF; streams = '0;
      for (int c = 0; c < 8; c++) begin
         w = (last + 1) % R;
         @(negedge clk);
         checks++; if (acks !== 4'(1 << w)) $display("FAIL rr_order: got %b want %b", acks, 4'(1 << w)); else passes++;
         for (int i = 0; i < R; i++) cnt[i] += int'(acks[i]);
         sb.push_back({2'(w), 32'hA0 + 32'(w)});
         tick();
         last = w;
      end
      sends = '0;
      tick();
      for (int i = 0; i < R; i++) begin
         checks++; if (cnt[i] !== 2) $display("FAIL rr_share_%0d: got %0d want 2", i, cnt[i]); else passes++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      datas[1] = 32'h51; datas[3] = 32'h53;
      sends = 4'b1010; out_ack = 1'b0;
      @(negedge clk);
      checks++; if (acks !== 4'b0010) $display("FAIL bp_first: got %b want 0010", acks); else passes++;
      sb.push_back({2'd1, 32'h51});
      tick();
      sends = 4'b1000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (acks !== 4'b0000) $display("FAIL bp_stall: got %b want 0000", acks); else passes++;
         checks++; if (out_data !== 32'h51 || out_source !== 2'd1)
            $display("FAIL bp_hold: got src %0d data %h want src 1 data 51", out_source, out_data); else passes++;
         tick();
      end
      out_ack = 1'b1;
      @(negedge clk);
      checks++; if (acks !== 4'b1000) $display("FAIL bp_release: got %b want 1000", acks); else passes++;
      sb.push_back({2'd3, 32'h53});
      tick();
      sends = '0;
      tick();
      last = 3;
   endtask

   task automatic test_stream_lock();
      out_ack = 1'b1;
      datas[1] = 32'h61; sends = 4'b0010; streams = 4'b0010;
      @(negedge clk);
      checks++; if (acks !== 4'b0010) $display("FAIL lock_w1: got %b want 0010", acks); else passes++;
      sb.push_back({2'd1, 32'h61});
      tick();
      checks++; if (busy !== 1'b1) $display("FAIL lock_busy: got %b want 1", busy); else passes++;
      datas[0] = 32'h70; datas[1] = 32'h62; sends = 4'b0011;
      @(negedge clk);
      checks++; if (acks !== 4'b0010) $display("FAIL lock_w2: got %b want 0010", acks); else passes++;
      sb.push_back({2'd1, 32'h62});
      tick();
      sends = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (acks !== 4'b0000) $display("FAIL lock_idle_gap: got %b want 0000", acks); else passes++;
         tick();
         checks++; if (busy !== 1'b1) $display("FAIL lock_gap_busy: got %b want 1", busy); else passes++;
      end
      datas[1] = 32'h63; sends = 4'b0011; streams = 4'b0000;
      @(negedge clk);
      checks++; if (acks !== 4'b0010) $display("FAIL lock_w3: got %b want 0010", acks); else passes++;
      sb.push_back({2'd1, 32'h63});
      tick();
      checks++; if (busy !== 1'b0) $display("FAIL lock_release: got %b want 0", busy); else passes++;
      sends = 4'b0001;
      @(negedge clk);
      checks++; if (acks !== 4'b0001) $display("FAIL lock_next: got %b want 0001", acks); else passes++;
      sb.push_back({2'd0, 32'h70});
      tick();
      sends = '0;
      tick();
   endtask

   task automatic test_abandon_and_mid_reset();
      out_ack = 1'b1;
      datas[2] = 32'h82; datas[3] = 32'h83;
      sends = 4'b1100; streams = 4'b0100;
      @(negedge clk);
      checks++; if (acks !== 4'b0100) $display("FAIL abandon_lock: got %b want 0100", acks); else passes++;
      sb.push_back({2'd2, 32'h82});
      tick();
      checks++; if (busy !== 1'b1) $display("FAIL abandon_busy: got %b want 1", busy); else passes++;
      sends = 4'b1000; streams = '0;
      @(negedge clk);
      checks++; if (acks !== 4'b0000) $display("FAIL abandon_cycle: got %b want 0000", acks); else passes++;
      tick();
      checks++; if (busy !== 1'b0) $display("FAIL abandon_clear: got %b want 0", busy); else passes++;
      @(negedge clk);
      checks++; if (acks !== 4'b1000) $display("FAIL abandon_next: got %b want 1000", acks); else passes++;
      sb.push_back({2'd3, 32'h83});
      tick();
      sends = '0;
      tick();

      // Capture a locking word, then reset with it still buffered.
      out_ack = 1'b0;
      datas[1] = 32'h91; sends = 4'b0010; streams = 4'b0010;
      @(negedge clk);
      checks++; if (acks !== 4'b0010) $display("FAIL midrst_capture: got %b want 0010", acks); else passes++;
      tick();
      checks++; if (out_send !== 1'b1 || busy !== 1'b1)
         $display("FAIL midrst_loaded: got send %b busy %b want 1 1", out_send, busy); else passes++;
      reset = 1'b1;
      @(negedge clk);
      checks++; if (acks !== 4'b0000) $display("FAIL midrst_acks: got %b want 0000", acks); else passes++;
      tick();
      reset = 1'b0; sends = '0; streams = '0;
      checks++; if (out_send !== 1'b0 || busy !== 1'b0)
         $display("FAIL midrst_cleared: got send %b busy %b want 0 0", out_send, busy); else passes++;
      tick();
   endtask

   initial begin
      reset = 1'b1; sends = '0; streams = '0; out_ack = 1'b0; datas = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_stream_lock();
      test_abandon_and_mid_reset();
      checks++;
      if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uarc_send_arbiter.md
# uarc_send_arbiter

Round-robin arbiter that shares one UARC receiver bus send channel among `REQUESTERS` sending cores. It gathers per-requester send/data/ack handshakes into a single-entry output buffer and presents that buffer on one send/data/ack channel. The channel attaches to a core's `receiver_sends`/`receiver_datas`/`receiver_send_acks` port. A requester may lock the grant with its stream line so that a multi-word burst is not interleaved with other requesters' words.

## Interface
- `WORD_WIDTH`, 32: data word width.
- `REQUESTERS`, 4: number of sending requesters; at least 2.
- `SEL_WIDTH`, `$clog2(REQUESTERS)`: width of the requester index.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_sends`  in  REQUESTERS: requester i has a word on `req_datas[i]`.
- `req_streams`  in  REQUESTERS: requester i wants to keep the grant after its current word.
- `req_datas`  in  [REQUESTERS-1:0][WORD_WIDTH-1:0]: per-requester data.
- `req_send_acks`  out  REQUESTERS: combinational; at most one bit is high. Bit i high means requester i's word is taken at this edge.
- `out_send`  out  1: buffer valid; the word on `out_data` is offered.
- `out_data`  out  WORD_WIDTH: buffered word.
- `out_source`  out  SEL_WIDTH: index of the requester that supplied `out_data`.
- `out_send_ack`  in  1: the receiver consumes `out_data` at this edge.
- `busy`  out  1: the grant is locked to one requester.

## Operation
**Transfer rule.** A word transfers on any rising edge where send and ack are both high. This applies on both sides of the arbiter.

**Capture.**
- `can_capture = !out_send || out_send_ack`.
- Eligible set:
  - when `busy` is 0: all i with `req_sends[i]`;
  - when `busy` is 1: only `lock_owner`, and only if `req_sends[lock_owner]` is high.
- If `can_capture` and the eligible set is non-empty, the winner is chosen as follows.
  - When locked, the winner is `lock_owner`.
  - Otherwise it is the first eligible index searching `ptr+1, ptr+2, …` modulo `REQUESTERS`.
- `req_send_acks[winner]` goes high in the same cycle.
- At the edge:
  - `out_data <= req_datas[winner]`;
  - `out_source <= winner`;
  - `out_send <= 1`;
  - `ptr <= winner`.
- If `out_send_ack` is high with no capture, then `out_send <= 0`. `out_data` and `out_source` hold their values.

**Lock.**
- A capture from i with `req_streams[i]` high sets `busy <= 1` and `lock_owner <= i`.
- A capture from the owner with its stream line low clears `busy`.
- The owner abandons the lock when it has `req_sends` and `req_streams` both low in any cycle. The lock clears at that edge.
- While locked, other requesters are never acked, even when the owner is idle.

**Reset.** The following reset values apply:
- `out_send` = 0, `out_data` = 0, `out_source` = 0;
- `busy` = 0, `lock_owner` = 0;
- `ptr` = `REQUESTERS-1`, so the first search starts at index 0.

`req_send_acks` is forced to 0 while `reset` is high.

## Timing
- **Latency.** One cycle from requester transfer to `out_send` high.
- **Throughput.** One word per cycle when `out_send_ack` is held high: consume and capture on the same edge, with `out_send` staying high.
- **Stability.** Once `out_send` is high, `out_data`/`out_source` must not change until the edge where `out_send_ack` is seen. `out_send` never drops without an ack.
- **Full buffer.** With `out_send` high and `out_send_ack` low, all `req_send_acks` are 0 and requesters stall.
- **Simultaneous requests.** Exactly one winner per cycle. Losers keep `req_sends` high and win on later cycles in rotation.
- **Lock and ack on the same edge.** A lock set on the same edge as an out ack takes effect for the next cycle's selection.
- **Reset mid-transfer.** The buffered word is discarded and the lock is dropped. Nothing is acked during the reset cycle.
- **Ack with empty buffer.** `out_send_ack` while `out_send` is 0 is ignored.

## Test plan
- **Reset.** Assert reset for 2 cycles with all `req_sends` = 1. Required: `out_send` = 0, `req_send_acks` = 0, `busy` = 0 throughout. At the first cycle after release, ack bit 0 is high.
- **Single requester, full rate.** Requester 2 sends 0x11, 0x22, 0x33 on consecutive cycles with `out_send_ack` tied high. Required: `out_data` 0x11, 0x22, 0x33 on cycles 1–3; `out_source` = 2; `out_send` is high continuously with no gaps.
- **Round-robin fairness.** All 4 requesters hold send with data 0xA0+i, ack tied high. Required: grant order 0, 1, 2, 3, 0, 1 …, and each requester gets exactly 1 of every 4 words.
- **Backpressure.** Requesters 1 and 3 send; `out_send_ack` is low for 5 cycles. Required: `out_data` holds requester 1's word, no further acks, then requester 3 is acked on the edge `out_send_ack` rises.
- **Stream lock.** Requester 1 sends 3 words, the first two with stream = 1 and the last with stream = 0; requester 0 sends continuously. Required: `busy` = 1 after word 1; the sequence is 1, 1, 1, then 0. Requester 0 is not acked during a 2-cycle owner-idle gap with stream still high.
- **Lock abandon and mid-reset.** Requester 2 locks, then drops send and stream. Required: `busy` = 0 next cycle and requester 3 wins. Separately, reset while `out_send` = 1 gives `out_send` = 0 and `busy` = 0 on the following cycle.
